// File: rtl/utopia_phy_tx.sv
// Utopia Level 1 PHY-side transmit cell buffer: stores whole 53-byte cells and plays them out under en.
// Optional HEC insertion on written byte 4 when UTOPIA_HEC_GEN_EN is defined.
`timescale 1ns/1ps
module utopia_phy_tx #(
  parameter int IfWidth    = 8,
  parameter int CELL_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic [7:0]         wr_data,
  input  logic               wr_sop,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [IfWidth-1:0] data,
  output logic               soc,
  input  logic               en,
  output logic               clav,
  output logic               drop_err,
  output logic [15:0]        cells_sent
);
  localparam int CellBytes = 53;
  localparam int SW = (CELL_DEPTH > 1) ? $clog2(CELL_DEPTH) : 1;
  localparam int CW = $clog2(CELL_DEPTH + 1);
  localparam int AW = $clog2(CELL_DEPTH * CellBytes);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_mem [CELL_DEPTH*CellBytes];
  logic [SW-1:0]        r_wslot;
  logic [SW-1:0]        r_rslot;
  logic [5:0]           r_wi;
  logic [5:0]           r_ri;
  logic [CW-1:0]        r_avail;
  logic                 r_busy;
  logic [IfWidth-1:0]   r_data;
  logic                 r_soc;
  logic                 r_drop;
  logic [15:0]          r_sent;

  logic                 w_start;
  logic                 w_adv;
  logic                 w_last;
  logic                 w_acc;
  logic                 w_store;
  logic                 w_commit;
  logic                 w_drop;
  logic [5:0]           w_widx;
  logic [AW-1:0]        w_waddr;
  logic [AW-1:0]        w_raddr;
  logic [7:0]           w_wbyte;
  logic [CW:0]          w_used;

  function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
    return (s == SW'(CELL_DEPTH - 1)) ? '0 : s + SW'(1);
  endfunction

  // Occupancy counts both committed cells and the one being played out
  assign w_used   = {1'b0, r_avail} + (CW+1)'(r_busy);
  assign wr_ready = w_used < (CW+1)'(CELL_DEPTH);
  assign clav     = (r_avail != '0);
  assign data       = r_data;
  assign soc        = r_soc;
  assign drop_err   = r_drop;
  assign cells_sent = r_sent;

  assign w_acc    = wr_valid && wr_ready;
  assign w_store  = w_acc && (wr_sop || (r_wi != 6'd0));
  assign w_commit = w_acc && !wr_sop && (r_wi == 6'd52);
  assign w_drop   = w_acc && ((wr_sop && (r_wi != 6'd0)) || (!wr_sop && (r_wi == 6'd0)));
  assign w_widx   = wr_sop ? 6'd0 : r_wi;
  assign w_waddr  = AW'(r_wslot) * AW'(CellBytes) + AW'(w_widx);
  assign w_raddr  = AW'(r_rslot) * AW'(CellBytes) + (w_start ? AW'(0) : AW'(r_ri));

`ifdef UTOPIA_HEC_GEN_EN
  logic [7:0] r_hec;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    end
    return x;
  endfunction

  assign w_wbyte = (!wr_sop && (r_wi == 6'd4)) ? (r_hec ^ 8'h55) : wr_data;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_hec <= 8'h00;
    end else if (w_acc && wr_sop) begin
      r_hec <= crc8(8'h00, wr_data);
    end else if (w_store && (r_wi < 6'd4)) begin
      r_hec <= crc8(r_hec, wr_data);
    end
  end
`else
  assign w_wbyte = wr_data;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!en && (r_avail != '0)) begin
          w_start     = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (!en) begin
          w_adv = 1'b1;
          if (r_ri == 6'd52) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_store) begin
      r_mem[w_waddr] <= w_wbyte;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_wslot <= '0;
      r_wi    <= 6'd0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_acc) begin
        if (wr_sop) begin
          r_wi <= 6'd1;
        end else if (r_wi == 6'd52) begin
          r_wi    <= 6'd0;
          r_wslot <= next_slot(r_wslot);
        end else if (r_wi != 6'd0) begin
          r_wi <= r_wi + 6'd1;
        end
      end
    end
  end

  // A commit and a cell start on the same edge cancel in the available count
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_avail <= '0;
      r_busy  <= 1'b0;
    end else begin
      case ({w_commit, w_start})
        2'b10:   r_avail <= r_avail + CW'(1);
        2'b01:   r_avail <= r_avail - CW'(1);
        default: r_avail <= r_avail;
      endcase
      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_rslot <= '0;
      r_ri    <= 6'd0;
      r_data  <= '0;
      r_soc   <= 1'b0;
      r_sent  <= 16'd0;
    end else begin
      r_soc <= w_start;
      if (w_start || w_adv) begin
        r_data <= r_mem[w_raddr];
      end
      if (w_start) begin
        r_ri <= 6'd1;
      end else if (w_last) begin
        r_ri    <= 6'd0;
        r_rslot <= next_slot(r_rslot);
        r_sent  <= r_sent + 16'd1;
      end else if (w_adv) begin
        r_ri <= r_ri + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_utopia_phy_tx.sv
// Directed bench for utopia_phy_tx with a cell scoreboard; honours UTOPIA_HEC_GEN_EN like the design.
`timescale 1ns/1ps
module tb_utopia_phy_tx;
  localparam int DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_sop = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  data;
  logic        soc;
  logic        en = 1'b1;
  logic        clav;
  logic        drop_err;
  logic [15:0] cells_sent;

  utopia_phy_tx #(.IfWidth(8), .CELL_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .wr_data(wr_data), .wr_sop(wr_sop),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .data(data), .soc(soc), .en(en),
    .clav(clav), .drop_err(drop_err), .cells_sent(cells_sent)
  );

  always #5 clk_in = ~clk_in;

  int          n_vec = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  m_cell [53];
  logic [7:0]  pat [53];
  int          m_wi = 0, m_avail = 0, m_busy = 0, m_ri = 0, n_drop_seen = 0;
  bit          m_send = 0, m_drop = 0, m_acc = 0;
  logic [15:0] m_sent = 16'd0;
  logic [7:0]  last_data = 8'h00;

  function automatic logic [7:0] ref_hec(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] c;
    logic [31:0] hdr;
    c = 8'h00;
    hdr = {b0, b1, b2, b3};
    for (int k = 31; k >= 0; k--) begin
      if (c[7] ^ hdr[k]) c = {c[6:0], 1'b0} ^ 8'h07;
      else               c = {c[6:0], 1'b0};
    end
    return c ^ 8'h55;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic commit_cell();
    logic [7:0] b;
    for (int i = 0; i < 53; i++) begin
      b = m_cell[i];
`ifdef UTOPIA_HEC_GEN_EN
      if (i == 4) b = ref_hec(m_cell[0], m_cell[1], m_cell[2], m_cell[3]);
`endif
      exp_q.push_back({(i == 0), b});
    end
  endtask

  // One clock: advance the reference model, step the DUT, compare every output.
  task automatic cyc();
    bit prod, start, ready_pre;
    logic [8:0] e;
    prod = !en && (m_send || (m_avail != 0));
    start = prod && !m_send;
    ready_pre = (m_avail + m_busy) < DEPTH;
    m_acc = wr_valid && ready_pre;
    m_drop = 0;
    e = {1'b0, last_data};
    if (prod) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_underflow: observed 0 entries expected at least 1");
      end
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (start) begin
        m_avail--; m_busy = 1; m_send = 1; m_ri = 1;
      end else if (m_ri == 52) begin
        m_send = 0; m_busy = 0; m_ri = 0; m_sent++;
      end else begin
        m_ri++;
      end
    end
    if (m_acc) begin
      if (wr_sop) begin
        m_drop = (m_wi != 0); m_cell[0] = wr_data; m_wi = 1;
      end else if (m_wi == 0) begin
        m_drop = 1;
      end else begin
        m_cell[m_wi] = wr_data;
        if (m_wi == 52) begin
          commit_cell(); m_avail++; m_wi = 0;
        end else begin
          m_wi++;
        end
      end
    end
    @(posedge clk_in);
    #1;
    if (prod) begin
      check("data", data, e[7:0]);
      check("soc", soc, e[8]);
      last_data = e[7:0];
    end else begin
      check("data_hold", data, last_data);
      check("soc_idle", soc, 0);
    end
    check("clav", clav, (m_avail != 0));
    check("wr_ready", wr_ready, ((m_avail + m_busy) < DEPTH));
    check("drop_err", drop_err, m_drop);
    check("cells_sent", cells_sent, m_sent);
    if (drop_err) n_drop_seen++;
  endtask

  task automatic write_pat();
    int tries;
    for (int i = 0; i < 53; i++) begin
      wr_valid = 1'b1; wr_sop = (i == 0); wr_data = pat[i];
      tries = 0;
      do begin
        cyc(); tries++;
      end while (!m_acc && tries < 400);
      n_vec++;
      assert (m_acc) else begin
        n_err++;
        $error("FAIL write_timeout: observed no accept expected accept of byte %0d", i);
      end
    end
    wr_valid = 1'b0; wr_sop = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    en = 1'b0;
    while ((exp_q.size() != 0 || m_send) && n < 1000) begin
      cyc(); n++;
    end
    n_vec++;
    assert (n < 1000) else begin
      n_err++;
      $error("FAIL drain_timeout: observed %0d cycles expected < 1000", n);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; wr_valid = 1'b0; wr_sop = 1'b0;
    #1;
    check("rst_soc", soc, 0);
    check("rst_clav", clav, 0);
    check("rst_data", data, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_drop_err", drop_err, 0);
    check("rst_cells_sent", cells_sent, 0);
    exp_q.delete();
    m_wi = 0; m_avail = 0; m_busy = 0; m_ri = 0; m_send = 0; m_sent = 16'd0; last_data = 8'h00;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int drops0;
    logic [15:0] sent0;
    do_reset();
    repeat (3) cyc();

    // Single cell, bytes equal to index
    for (int i = 0; i < 53; i++) pat[i] = 8'(i);
    write_pat();
    check("clav_after_commit", clav, 1);
    drain();
    en = 1'b1;
    cyc();
    check("cells_sent_one", cells_sent, 16'd1);

    // Fill all slots, then free one while a fifth cell waits
    for (int c = 0; c < DEPTH; c++) begin
      for (int i = 0; i < 53; i++) pat[i] = 8'(c * 16 + i + 3);
      write_pat();
    end
    check("wr_ready_full", wr_ready, 0);
    en = 1'b0;
    repeat (53) cyc();
    check("wr_ready_freed", wr_ready, 1);
    for (int i = 0; i < 53; i++) pat[i] = 8'(8'hA0 ^ i);
    write_pat();
    drain();
    en = 1'b1;
    cyc();

    // en pause mid-cell
    for (int i = 0; i < 53; i++) pat[i] = 8'(i);
    write_pat();
    en = 1'b0;
    repeat (21) cyc();
    check("pause_before", data, 8'h14);
    en = 1'b1;
    repeat (3) cyc();
    check("pause_hold_data", data, 8'h14);
    check("pause_hold_soc", soc, 0);
    en = 1'b0;
    cyc();
    check("pause_resume", data, 8'h15);
    drain();
    en = 1'b1;
    cyc();

    // Stray byte, then a partial cell interrupted by a fresh SOP
    drops0 = n_drop_seen;
    sent0 = cells_sent;
    wr_valid = 1'b1; wr_sop = 1'b0; wr_data = 8'hAA;
    cyc();
    check("stray_drop", drop_err, 1);
    check("stray_drop_count", n_drop_seen - drops0, 1);
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1; wr_sop = (i == 0); wr_data = 8'(8'hE0 + i);
      cyc();
    end
    wr_valid = 1'b0; wr_sop = 1'b0;
    drops0 = n_drop_seen;
    for (int i = 0; i < 53; i++) pat[i] = 8'(8'h40 + i);
    write_pat();
    check("restart_one_drop", n_drop_seen - drops0, 1);
    drain();
    repeat (10) cyc();
    en = 1'b1;
    check("restart_one_cell", cells_sent - sent0, 1);

    // HEC field
    for (int i = 0; i < 53; i++) pat[i] = 8'(i);
    pat[0] = 8'h00; pat[1] = 8'h00; pat[2] = 8'h00; pat[3] = 8'h01; pat[4] = 8'hFF;
    write_pat();
    en = 1'b0;
    repeat (5) cyc();
`ifdef UTOPIA_HEC_GEN_EN
    check("hec_byte4", data, 8'h52);
`else
    check("hec_byte4", data, 8'hFF);
`endif
    drain();
    en = 1'b1;
    cyc();

    // Reset while byte 30 of a cell is on the bus, with another cell stored
    for (int i = 0; i < 53; i++) pat[i] = 8'(i);
    write_pat();
    for (int i = 0; i < 53; i++) pat[i] = 8'(8'h80 + i);
    write_pat();
    en = 1'b0;
    repeat (31) cyc();
    check("mid_cell_byte30", data, 8'h1E);
    do_reset();
    en = 1'b0;
    repeat (60) cyc();
    check("no_residual_sent", cells_sent, 0);
    check("no_residual_clav", clav, 0);
    en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/utopia_phy_tx.md
# utopia_phy_tx

PHY-side Utopia Level 1 cell source: the transmitting end that feeds an ATM-layer Utopia receiver over the 8-bit `data`/`soc`/`en`/`clav` bus. The block buffers whole 53-byte ATM cells written from a local byte stream. It advertises cell availability on `clav` and, under receiver control via active-low `en`, emits each cell octet by octet with `soc` marking byte 0. It sits between the line/PHY loader and the switch core's receive port.

## Interface
- `IfWidth`, 8: bus width; the only legal value is 8.
- `CELL_DEPTH`, 4: cell slots buffered (≥2); storage is `CELL_DEPTH`×53 bytes.
- `clk_in`  input  1  single clock; all logic on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `wr_data`  input  8  cell byte from loader.
- `wr_sop`  input  1  marks `wr_data` as byte 0 of a cell.
- `wr_valid`  input  1  loader byte valid.
- `wr_ready`  output  1  byte accepted when `wr_valid && wr_ready`.
- `data`  output  IfWidth  Utopia cell octet to receiver.
- `soc`  output  1  start of cell, high with byte 0.
- `en`  input  1  receiver read enable, active-low.
- `clav`  output  1  a complete, unstarted cell is available.
- `drop_err`  output  1  one-cycle pulse: malformed cell discarded.
- `cells_sent`  output  16  count of cells fully transmitted, wraps at 0xFFFF→0.

## Operation
- Write side: byte index `wi` 0..52 into the current free slot. Accepted byte at `wi`=52 commits the slot and increments `avail`; `wi`→0.
- `wr_ready` = (committed + in-transmit slots) < `CELL_DEPTH`.
- `wr_sop`=1 with `wi`≠0: partial cell discarded, byte stored as byte 0 of a new cell, `wi`→1, `drop_err` pulses.
- `wr_sop`=0 with `wi`=0: byte dropped, `drop_err` pulses, `wi` stays 0.
- Read FSM, two states:
  - IDLE: at an edge with `en`=0 and `avail`≠0, drive byte 0 with `soc`=1, decrement `avail`, `ri`→1, go to SEND.
  - SEND: each edge with `en`=0 drives byte `ri` with `soc`=0 and increments `ri`. At the edge driving byte 52, free the slot, increment `cells_sent`, and return to IDLE.
  - `en`=1: `data` holds, `soc`→0, `ri` holds.
- `clav` = (`avail`≠0), from registered state.
- Slots are read in commit order (circular, wrap at `CELL_DEPTH`−1→0).
- A same-edge commit and slot free both apply; counts stay consistent.

## Timing
- Reset values: `data`=0, `soc`=0, `clav`=0, `drop_err`=0, `cells_sent`=0, `wr_ready`=1, FSM=IDLE. Partial and stored cells are lost, including a cell mid-transmit.
- `clav` rises the cycle after the edge accepting byte 52. It falls the cycle after the edge driving byte 0 of the last available cell.
- The octet appears one cycle after the edge sampling `en`=0. A full cell with `en` held low takes 53 consecutive cycles.
- IDLE with `en`=0 and `avail`=0 leaves outputs unchanged.
- Back-to-back cells: with `en` low and `avail`≠0, byte 0 of the next cell follows byte 52 on the very next edge.
- Full buffer: `wr_ready` falls the cycle after the commit that fills the last slot. It rises the cycle after byte 52 of a cell is driven.

## Configuration
- `UTOPIA_HEC_GEN_EN` defined: HEC is computed at write time over bytes 0–3 (CRC-8, polynomial x⁸+x²+x+1, init 0x00, result XOR 0x55). It is stored in place of written byte 4.
- Not defined: byte 4 passes through unchanged; no CRC logic.

## Test plan
- Reset asserted mid-cell (byte 30) → next cycle `soc`=0, `clav`=0, `data`=0, `wr_ready`=1. After release, no residual cell is ever transmitted.
- One cell with bytes = index (0x00..0x34), `en` held low → `soc`=1 with 0x00, then 0x01..0x34 over 52 cycles. `clav` falls after byte 0; `cells_sent`=1.
- Write 4 cells with `CELL_DEPTH`=4 → `wr_ready`=0 after the 212th byte. Transmit one cell → `wr_ready`=1 after its byte 0x34.
- `en` raised for 3 cycles after byte 0x14 is driven → `data` holds 0x14 with `soc`=0, then 0x15 resumes.
- `wr_sop` reasserted at `wi`=10, followed by a full cell → one `drop_err` pulse; exactly one cell is transmitted, matching the second write.
- Header 00 00 00 01 with written byte 4 = 0xFF → transmitted byte 4 = 0x52 with `UTOPIA_HEC_GEN_EN`, 0xFF without.
